riscv_control: RTL and testbench

- Main control decoder for the single-cycle/pipelined RV32I datapath.
- Decodes a 32-bit instruction word into the datapath control strobes: Branch, MemRead, MemtoReg, ALUOp, MemWrite, ALUSrc and RegWrite.
- Outputs are registered, giving one cycle of latency, and the block flags illegal encodings.
- Sits between instruction fetch and the ALU-control, register-file and data-memory blocks.

---
 rtl/riscv_control.sv | 124 ++++++++++++
 tb/tb_riscv_control.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_control.sv
// RV32I main control decoder: maps an instruction word to registered datapath
// control strobes, with one cycle of latency and an illegal-encoding flag.
module riscv_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic        instr_valid,
    output logic        Branch,
    output logic        MemRead,
    output logic        MemtoReg,
    output logic [1:0]  ALUOp,
    output logic        MemWrite,
    output logic        ALUSrc,
    output logic        RegWrite,
    output logic        ctrl_valid,
    output logic        illegal
);

    localparam logic [6:0] OpRType = 7'b0110011;
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpIType = 7'b0010011;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign funct7 = instruction[31:25];

    logic       branch_d, mem_read_d, mem_to_reg_d, mem_write_d, alu_src_d, reg_write_d;
    logic [1:0] alu_op_d;
    logic       valid_d, illegal_d;
    logic       bad;

    always_comb begin
        branch_d     = 1'b0;
        mem_read_d   = 1'b0;
        mem_to_reg_d = 1'b0;
        mem_write_d  = 1'b0;
        alu_src_d    = 1'b0;
        reg_write_d  = 1'b0;
        alu_op_d     = 2'b00;
        bad          = 1'b0;

        case (opcode)
            OpRType: begin
                reg_write_d = 1'b1;
                alu_op_d    = 2'b10;
                bad = !(funct7 == 7'b0000000 || funct7 == 7'b0100000) ||
                      (funct7 == 7'b0100000 && !(funct3 == 3'b000 || funct3 == 3'b101));
            end
            OpLoad: begin
                alu_src_d    = 1'b1;
                mem_to_reg_d = 1'b1;
                reg_write_d  = 1'b1;
                mem_read_d   = 1'b1;
                bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OpStore: begin
                alu_src_d   = 1'b1;
                mem_write_d = 1'b1;
                bad = (funct3 > 3'b010);
            end
            OpBranch: begin
                branch_d = 1'b1;
                alu_op_d = 2'b01;
                bad = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OpIType: begin
                alu_src_d   = 1'b1;
                reg_write_d = 1'b1;
                alu_op_d    = 2'b11;
                bad = (funct3 == 3'b001 && funct7 != 7'b0000000) ||
                      (funct3 == 3'b101 && !(funct7 == 7'b0000000 || funct7 == 7'b0100000));
            end
            default: bad = 1'b1;
        endcase

        // Low bits other than 11 never match a listed opcode, but keep the rule explicit.
        if (instruction[1:0] != 2'b11) bad = 1'b1;

        valid_d   = instr_valid;
        illegal_d = instr_valid && bad;

        // Invalid or illegal words must not disturb the datapath.
        if (!instr_valid || bad) begin
            branch_d     = 1'b0;
            mem_read_d   = 1'b0;
            mem_to_reg_d = 1'b0;
            mem_write_d  = 1'b0;
            alu_src_d    = 1'b0;
            reg_write_d  = 1'b0;
            alu_op_d     = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Branch     <= 1'b0;
            MemRead    <= 1'b0;
            MemtoReg   <= 1'b0;
            ALUOp      <= 2'b00;
            MemWrite   <= 1'b0;
            ALUSrc     <= 1'b0;
            RegWrite   <= 1'b0;
            ctrl_valid <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            Branch     <= branch_d;
            MemRead    <= mem_read_d;
            MemtoReg   <= mem_to_reg_d;
            ALUOp      <= alu_op_d;
            MemWrite   <= mem_write_d;
            ALUSrc     <= alu_src_d;
            RegWrite   <= reg_write_d;
            ctrl_valid <= valid_d;
            illegal    <= illegal_d;
        end
    end

endmodule

// File: tb/tb_riscv_control.sv
// Self-checking bench for riscv_control: directed scenarios plus randomized
// instruction streams compared against a rule-level reference model.
module tb_riscv_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ctrl_valid, illegal;
    logic [1:0]  ALUOp;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    riscv_control dut (
        .clk        (clk),
        .rst        (rst),
        .instruction(instruction),
        .instr_valid(instr_valid),
        .Branch     (Branch),
        .MemRead    (MemRead),
        .MemtoReg   (MemtoReg),
        .ALUOp      (ALUOp),
        .MemWrite   (MemWrite),
        .ALUSrc     (ALUSrc),
        .RegWrite   (RegWrite),
        .ctrl_valid (ctrl_valid),
        .illegal    (illegal)
    );

    // Bit order: Branch MemRead MemtoReg ALUOp[1:0] MemWrite ALUSrc RegWrite ctrl_valid illegal
    localparam logic [9:0] ExpZero  = 10'b0_0_0_00_0_0_0_0_0;
    localparam logic [9:0] ExpR     = 10'b0_0_0_10_0_0_1_1_0;
    localparam logic [9:0] ExpLoad  = 10'b0_1_1_00_0_1_1_1_0;
    localparam logic [9:0] ExpStore = 10'b0_0_0_00_1_1_0_1_0;
    localparam logic [9:0] ExpBr    = 10'b1_0_0_01_0_0_0_1_0;
    localparam logic [9:0] ExpI     = 10'b0_0_0_11_0_1_1_1_0;
    localparam logic [9:0] ExpIll   = 10'b0_0_0_00_0_0_0_1_1;

    function automatic logic [9:0] observed();
        return {Branch, MemRead, MemtoReg, ALUOp, MemWrite, ALUSrc, RegWrite, ctrl_valid, illegal};
    endfunction

    // Reference model built from the decode table and legality rules.
    function automatic logic [9:0] model(logic [31:0] i, logic v, logic r);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [9:0] e;
        bit ok;
        op = i[6:0];
        f3 = i[14:12];
        f7 = i[31:25];
        if (r || !v) return ExpZero;
        ok = (i[1:0] == 2'b11);
        case (op)
            7'h33: begin
                e = ExpR;
                if (!(f7 inside {7'h00, 7'h20})) ok = 0;
                if (f7 == 7'h20 && !(f3 inside {3'd0, 3'd5})) ok = 0;
            end
            7'h03: begin
                e = ExpLoad;
                if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) ok = 0;
            end
            7'h23: begin
                e = ExpStore;
                if (!(f3 inside {3'd0, 3'd1, 3'd2})) ok = 0;
            end
            7'h63: begin
                e = ExpBr;
                if (f3 inside {3'd2, 3'd3}) ok = 0;
            end
            7'h13: begin
                e = ExpI;
                if (f3 == 3'd1 && f7 != 7'h00) ok = 0;
                if (f3 == 3'd5 && !(f7 inside {7'h00, 7'h20})) ok = 0;
            end
            default: begin
                e = ExpIll;
                ok = 0;
            end
        endcase
        return ok ? e : ExpIll;
    endfunction

    // Drive one word, advance one edge, return to 1 time unit after the edge.
    task automatic step(input logic [31:0] i, input logic v, input logic r);
        instruction = i;
        instr_valid = v;
        rst         = r;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(32'h007302B3, 1'b1, 1'b1);
        tests++;
        if (observed() !== ExpZero) begin
            fails++;
            $display("FAIL reset_cycle1 got=%b want=%b", observed(), ExpZero);
        end
        step(32'h007302B3, 1'b1, 1'b1);
        tests++;
        if (observed() !== ExpZero) begin
            fails++;
            $display("FAIL reset_cycle2 got=%b want=%b", observed(), ExpZero);
        end
        step(32'h007302B3, 1'b1, 1'b0);
        tests++;
        if (observed() !== ExpR) begin
            fails++;
            $display("FAIL reset_release got=%b want=%b", observed(), ExpR);
        end
    endtask

    task automatic test_rtype();
        step(32'h007302B3, 1'b1, 1'b0);
        tests++;
        if (observed() !== ExpR) begin
            fails++;
            $display("FAIL rtype_add got=%b want=%b", observed(), ExpR);
        end
        step(32'h407302B3, 1'b1, 1'b0);
        tests++;
        if (observed() !== ExpR) begin
            fails++;
            $display("FAIL rtype_sub got=%b want=%b", observed(), ExpR);
        end
    endtask

    task automatic test_load_store();
        step(32'h0002A303, 1'b1, 1'b0);
        tests++;
        if (observed() !== ExpLoad) begin
            fails++;
            $display("FAIL load_lw got=%b want=%b", observed(), ExpLoad);
        end
        step(32'h0062A023, 1'b1, 1'b0);
        tests++;
        if (observed() !== ExpStore) begin
            fails++;
            $display("FAIL store_sw got=%b want=%b", observed(), ExpStore);
        end
    endtask

    task automatic test_back_to_back();
        step(32'h00628463, 1'b1, 1'b0);
        tests++;
        if (observed() !== ExpBr) begin
            fails++;
            $display("FAIL b2b_beq got=%b want=%b", observed(), ExpBr);
        end
        step(32'h00530293, 1'b1, 1'b0);
        tests++;
        if (observed() !== ExpI) begin
            fails++;
            $display("FAIL b2b_addi got=%b want=%b", observed(), ExpI);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] words [3];
        words[0] = 32'h0000007F;
        words[1] = 32'h027302B3;
        words[2] = 32'h0002B303;
        foreach (words[k]) begin
            step(words[k], 1'b1, 1'b0);
            tests++;
            if (observed() !== ExpIll) begin
                fails++;
                $display("FAIL illegal_%0h got=%b want=%b", words[k], observed(), ExpIll);
            end
        end
    endtask

    task automatic test_invalid();
        step(32'h007302B3, 1'b0, 1'b0);
        tests++;
        if (observed() !== ExpZero) begin
            fails++;
            $display("FAIL invalid_word got=%b want=%b", observed(), ExpZero);
        end
    endtask

    task automatic test_mid_reset();
        step(32'h0002A303, 1'b1, 1'b0);
        tests++;
        if (observed() !== ExpLoad) begin
            fails++;
            $display("FAIL midrst_before got=%b want=%b", observed(), ExpLoad);
        end
        step(32'h0002A303, 1'b1, 1'b1);
        tests++;
        if (observed() !== ExpZero) begin
            fails++;
            $display("FAIL midrst_pulse got=%b want=%b", observed(), ExpZero);
        end
        step(32'h0002A303, 1'b1, 1'b0);
        tests++;
        if (observed() !== ExpLoad) begin
            fails++;
            $display("FAIL midrst_after got=%b want=%b", observed(), ExpLoad);
        end
    endtask

    task automatic test_random();
        logic [6:0]  ops [6];
        logic [31:0] w;
        logic        v, r;
        logic [9:0]  exp;
        ops[0] = 7'h33; ops[1] = 7'h03; ops[2] = 7'h23;
        ops[3] = 7'h63; ops[4] = 7'h13; ops[5] = 7'h00;
        for (int n = 0; n < 600; n++) begin
            w = $urandom;
            if ($urandom_range(0, 4) != 0) begin
                w[6:0] = ops[$urandom_range(0, 4)];
                case ($urandom_range(0, 2))
                    0: w[31:25] = 7'h00;
                    1: w[31:25] = 7'h20;
                    default: ;
                endcase
            end
            v = ($urandom_range(0, 7) != 0);
            r = ($urandom_range(0, 31) == 0);
            exp = model(w, v, r);
            step(w, v, r);
            tests++;
            if (observed() !== exp) begin
                fails++;
                $display("FAIL random_%0d instr=%h v=%b r=%b got=%b want=%b",
                         n, w, v, r, observed(), exp);
            end
            tests++;
            if ((MemRead && MemWrite) || (MemtoReg && !MemRead) || (Branch && RegWrite)) begin
                fails++;
                $display("FAIL exclusion_%0d got=%b want=no conflicting strobes", n, observed());
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        instruction = '0;
        instr_valid = 1'b0;
        #2;
        test_reset();
        test_rtype();
        test_load_store();
        test_back_to_back();
        test_illegal();
        test_invalid();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
